mem_stage_ctrl: RTL and testbench

- Memory-stage request controller; the producer side of the MEM/WB pipeline register.
- Takes the EX/MEM memory op and drives the dcache request until dhit. Captures and holds the load data.
- Drives enable_MEM_WB and flush_MEM_WB so WB sees exactly one copy of each instruction, or a bubble while memory stalls.
- Also owns the sticky halt freeze and a dhit watchdog.

---
 rtl/cpu_types_pkg.sv | 8 +
 rtl/mem_watchdog.sv | 31 +++
 rtl/mem_stage_ctrl.sv | 133 +++++++++++++
 tb/tb_mem_stage_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word and the memory-stage controller states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {IDLE, WAIT, DONE, HALTED} mem_ctrl_state_t;

endpackage

// File: rtl/mem_watchdog.sv
// Saturating up-counter with synchronous clear and a sticky flag that sets
// on the increment taken while the count sits at FLAG_AT.
module mem_watchdog #(
  parameter int             W       = 8,
  parameter logic [W-1:0]   FLAG_AT = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         flag
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      flag  <= 1'b0;
    end else begin
      if (clr) begin
        count <= '0;
      end else if (inc && (count != '1)) begin
        count <= count + W'(1);
      end
      if (inc && !clr && (count == FLAG_AT)) begin
        flag <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage dcache request controller feeding the MEM/WB register; owns the
// stall/enable/flush handshake, load-data buffer, sticky halt and dhit watchdog.
module mem_stage_ctrl
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             dREN_EX_MEM,
  input  logic             dWEN_EX_MEM,
  input  word_t            result_EX_MEM,
  input  word_t            storedata_EX_MEM,
  input  logic             halt_EX_MEM,
  input  logic             ihit,
  input  logic             dhit,
  input  word_t            dload,
  output logic             dmemREN,
  output logic             dmemWEN,
  output word_t            dmemaddr,
  output word_t            dmemstore,
  output word_t            dmemload,
  output logic             enable_MEM_WB,
  output logic             flush_MEM_WB,
  output logic             stall_mem,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;

  mem_ctrl_state_t state, next_state;
  word_t           load_buf;
  logic            memop, is_load, is_store;
  logic            req_ren, req_wen, outstanding, stall, enable, flush;
  logic            wd_clr;
  logic [WD_W-1:0] wd_count_unused;
  logic            stall_sat_unused;

  // A simultaneous load and store request is serviced as a load.
  assign is_load  = dREN_EX_MEM;
  assign is_store = dWEN_EX_MEM & ~dREN_EX_MEM;
  assign memop    = dREN_EX_MEM | dWEN_EX_MEM;

  always_comb begin
    next_state  = state;
    req_ren     = 1'b0;
    req_wen     = 1'b0;
    outstanding = 1'b0;
    stall       = 1'b0;
    case (state)
      IDLE: begin
        req_ren     = is_load;
        req_wen     = is_store;
        outstanding = memop & ~dhit;
        stall       = memop & ~dhit;
        if (memop && !dhit)      next_state = WAIT;
        else if (memop && !ihit) next_state = DONE;
      end
      WAIT: begin
        req_ren     = is_load;
        req_wen     = is_store;
        outstanding = ~dhit;
        stall       = ~dhit;
        if (dhit) next_state = ihit ? IDLE : DONE;
      end
      DONE: begin
        stall = ~ihit;
        if (ihit) next_state = IDLE;
      end
      HALTED: begin
        stall = 1'b1;
      end
    endcase
    enable = ihit & ~outstanding & (state != HALTED);
    flush  = ihit & outstanding;
    if (enable && halt_EX_MEM) next_state = HALTED;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      load_buf <= '0;
    end else begin
      state <= next_state;
      if (req_ren && dhit) load_buf <= dload;
    end
  end

  // Outputs are forced low while reset is held so a live request drops at once.
  always_comb begin
    dmemREN       = nRST & req_ren;
    dmemWEN       = nRST & req_wen;
    dmemaddr      = nRST ? result_EX_MEM : '0;
    dmemstore     = nRST ? storedata_EX_MEM : '0;
    enable_MEM_WB = nRST & enable;
    flush_MEM_WB  = nRST & flush;
    stall_mem     = nRST & stall;
    halted        = (state == HALTED);
    if (!nRST)                        dmemload = '0;
    else if (state == DONE || !dhit)  dmemload = load_buf;
    else                              dmemload = dload;
  end

  assign wd_clr = dhit | ((state == IDLE) & ~memop);

  mem_watchdog #(
    .W       (WD_W),
    .FLAG_AT (WD_W'(TIMEOUT_CYCLES - 1))
  ) u_watchdog (
    .clk   (CLK),
    .rst_n (nRST),
    .clr   (wd_clr),
    .inc   (outstanding),
    .count (wd_count_unused),
    .flag  (mem_timeout)
  );

  mem_watchdog #(
    .W       (CNT_W),
    .FLAG_AT ('1)
  ) u_stall_counter (
    .clk   (CLK),
    .rst_n (nRST),
    .clr   (1'b0),
    .inc   (stall & (state != HALTED)),
    .count (stall_cycles),
    .flag  (stall_sat_unused)
  );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: IDLE-state vector table plus multi-cycle
// sequences for miss, dhit-before-ihit, halt, watchdog and async reset.
module tb_mem_stage_ctrl;

  logic        CLK;
  logic        nRST;
  logic        dren, dwen, halt, ihit, dhit;
  logic [31:0] addr, sdata, dload;
  logic        dmemREN, dmemWEN, enable_MEM_WB, flush_MEM_WB, stall_mem;
  logic        halted, mem_timeout;
  logic [31:0] dmemaddr, dmemstore, dmemload, stall_cycles;

  int checks;
  int failures;

  mem_stage_ctrl #(.TIMEOUT_CYCLES(8), .CNT_W(32)) dut (
    .CLK              (CLK),
    .nRST             (nRST),
    .dREN_EX_MEM      (dren),
    .dWEN_EX_MEM      (dwen),
    .result_EX_MEM    (addr),
    .storedata_EX_MEM (sdata),
    .halt_EX_MEM      (halt),
    .ihit             (ihit),
    .dhit             (dhit),
    .dload            (dload),
    .dmemREN          (dmemREN),
    .dmemWEN          (dmemWEN),
    .dmemaddr         (dmemaddr),
    .dmemstore        (dmemstore),
    .dmemload         (dmemload),
    .enable_MEM_WB    (enable_MEM_WB),
    .flush_MEM_WB     (flush_MEM_WB),
    .stall_mem        (stall_mem),
    .halted           (halted),
    .mem_timeout      (mem_timeout),
    .stall_cycles     (stall_cycles)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        dren, dwen, ihit, dhit;
    logic [31:0] dload;
    logic        ren, wen, en, fl, st;
    logic [31:0] load;
  } vec_t;

  vec_t vecs[9];

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic r, input logic w, input logic h, input logic ih,
                        input logic dh, input logic [31:0] dl);
    dren = r; dwen = w; halt = h; ihit = ih; dhit = dh; dload = dl;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  task automatic chk_hs(input string tag, input logic en, input logic fl, input logic st);
    check1({tag, "_enable"}, enable_MEM_WB, en);
    check1({tag, "_flush"},  flush_MEM_WB,  fl);
    check1({tag, "_stall"},  stall_mem,     st);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    addr = 32'h0;
    sdata = 32'h0;
    nRST = 1'b0;
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
    addr = 32'h0000_0100;

    vecs[0] = '{1,0,1,1,32'hDEADBEEF, 1,0,1,0,0, 32'hDEADBEEF};
    vecs[1] = '{0,1,1,1,32'h12345678, 0,1,1,0,0, 32'h12345678};
    vecs[2] = '{1,0,1,0,32'hAAAAAAAA, 1,0,0,1,1, 32'h00000000};
    vecs[3] = '{1,1,0,0,32'h00000000, 1,0,0,0,1, 32'h00000000};
    vecs[4] = '{0,0,1,0,32'h00000000, 0,0,1,0,0, 32'h00000000};
    vecs[5] = '{0,0,0,0,32'h00000000, 0,0,0,0,0, 32'h00000000};
    vecs[6] = '{0,1,0,0,32'h00000000, 0,1,0,0,1, 32'h00000000};
    vecs[7] = '{1,0,0,1,32'h0BADF00D, 1,0,0,0,0, 32'h0BADF00D};
    vecs[8] = '{1,1,1,1,32'h13572468, 1,0,1,0,0, 32'h13572468};

    // Outputs held low during reset even with a live request on the inputs.
    #3;
    check1("rst_dmemREN", dmemREN, 1'b0);
    check1("rst_halted", halted, 1'b0);
    check1("rst_timeout", mem_timeout, 1'b0);
    check32("rst_dmemaddr", dmemaddr, 32'h0);
    check32("rst_dmemload", dmemload, 32'h0);
    check32("rst_stall_cycles", stall_cycles, 32'h0);
    chk_hs("rst", 1'b0, 1'b0, 1'b0);

    // IDLE vector table; inputs return to idle before each clock edge.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      addr  = 32'h0000_0100 + 32'(i * 4);
      sdata = ~addr;
      set_in(vecs[i].dren, vecs[i].dwen, 1'b0, vecs[i].ihit, vecs[i].dhit, vecs[i].dload);
      #2;
      check1($sformatf("v%0d_ren", i), dmemREN, vecs[i].ren);
      check1($sformatf("v%0d_wen", i), dmemWEN, vecs[i].wen);
      chk_hs($sformatf("v%0d", i), vecs[i].en, vecs[i].fl, vecs[i].st);
      check32($sformatf("v%0d_load", i), dmemload, vecs[i].load);
      check32($sformatf("v%0d_addr", i), dmemaddr, addr);
      check32($sformatf("v%0d_store", i), dmemstore, sdata);
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      next_cycle();
    end
    check32("table_stall_cycles", stall_cycles, 32'h0);

    // Load miss of 3 cycles with ihit held high.
    do_reset();
    addr = 32'h0000_0200;
    for (int c = 0; c < 3; c++) begin
      set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      #2;
      check1($sformatf("miss_c%0d_ren", c), dmemREN, 1'b1);
      chk_hs($sformatf("miss_c%0d", c), 1'b0, 1'b1, 1'b1);
      next_cycle();
    end
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hCAFEF00D);
    #2;
    chk_hs("miss_hit", 1'b1, 1'b0, 1'b0);
    check32("miss_hit_load", dmemload, 32'hCAFEF00D);
    next_cycle();
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    #2;
    check32("miss_stall_cycles", stall_cycles, 32'd3);
    check32("miss_hold_load", dmemload, 32'hCAFEF00D);
    chk_hs("miss_after", 1'b1, 1'b0, 1'b0);
    next_cycle();

    // Store: dhit at cycle 1, ihit at cycle 4.
    do_reset();
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
    #2;
    check1("st_c1_wen", dmemWEN, 1'b1);
    chk_hs("st_c1", 1'b0, 1'b0, 1'b0);
    for (int c = 2; c <= 3; c++) begin
      next_cycle();
      set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      #2;
      check1($sformatf("st_c%0d_wen", c), dmemWEN, 1'b0);
      chk_hs($sformatf("st_c%0d", c), 1'b0, 1'b0, 1'b1);
    end
    next_cycle();
    set_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    #2;
    check1("st_c4_wen", dmemWEN, 1'b0);
    chk_hs("st_c4", 1'b1, 1'b0, 1'b0);
    next_cycle();
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    #2;
    chk_hs("st_c5", 1'b1, 1'b0, 1'b0);
    next_cycle();

    // Same shape for a load: latched data held through cycles 2-4.
    do_reset();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h55AA55AA);
    #2;
    check1("ld_c1_ren", dmemREN, 1'b1);
    check32("ld_c1_load", dmemload, 32'h55AA55AA);
    for (int c = 2; c <= 4; c++) begin
      next_cycle();
      set_in(1'b1, 1'b0, 1'b0, (c == 4), 1'b0, 32'hFFFF_FFFF);
      #2;
      check1($sformatf("ld_c%0d_ren", c), dmemREN, 1'b0);
      check32($sformatf("ld_c%0d_load", c), dmemload, 32'h55AA55AA);
      check1($sformatf("ld_c%0d_enable", c), enable_MEM_WB, (c == 4));
    end
    next_cycle();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    check32("ld_stall_cycles", stall_cycles, 32'd2);
    next_cycle();

    // Halt: enable pulse, then frozen; later requests ignored.
    do_reset();
    set_in(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    #2;
    check1("halt_c1_enable", enable_MEM_WB, 1'b1);
    check1("halt_c1_halted", halted, 1'b0);
    for (int c = 2; c <= 4; c++) begin
      next_cycle();
      set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
      #2;
      check1($sformatf("halt_c%0d_halted", c), halted, 1'b1);
      check1($sformatf("halt_c%0d_ren", c), dmemREN, 1'b0);
      chk_hs($sformatf("halt_c%0d", c), 1'b0, 1'b0, 1'b1);
    end
    check32("halt_stall_cycles", stall_cycles, 32'd0);

    // Watchdog with TIMEOUT_CYCLES=8: request held, no dhit.
    do_reset();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int c = 1; c < 8; c++) next_cycle();
    #2;
    check1("to_c8_timeout", mem_timeout, 1'b0);
    next_cycle();
    #2;
    check1("to_c9_timeout", mem_timeout, 1'b1);
    check1("to_c9_ren", dmemREN, 1'b1);
    check32("to_c9_stall_cycles", stall_cycles, 32'd8);
    next_cycle();
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    #2;
    check1("to_hit_enable", enable_MEM_WB, 1'b1);
    next_cycle();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    check1("to_sticky", mem_timeout, 1'b1);
    next_cycle();

    // Async reset while in WAIT drops the request and discards the buffer.
    do_reset();
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11223344);
    next_cycle();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    next_cycle();
    next_cycle();
    #2;
    check1("ar_pre_ren", dmemREN, 1'b1);
    check32("ar_pre_load", dmemload, 32'h11223344);
    nRST = 1'b0;
    #1;
    check1("ar_ren", dmemREN, 1'b0);
    chk_hs("ar", 1'b0, 1'b0, 1'b0);
    check32("ar_stall_cycles", stall_cycles, 32'h0);
    check32("ar_load", dmemload, 32'h0);
    next_cycle();
    nRST = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    #2;
    chk_hs("ar_post", 1'b1, 1'b0, 1'b0);
    check32("ar_post_load", dmemload, 32'h0);
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
